// File: rtl/array_writer_pkg.sv
// Shared types and helpers for the array_writer table loader.
package array_writer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } array_writer_state_t;

   function automatic int depth(input int addr_bits);
      return 1 << addr_bits;
   endfunction

endpackage

// File: rtl/array_writer_if.sv
// Load stream, read port and status bundle for array_writer.
interface array_writer_if #(
   parameter int ADDR_BITS = 2,
   parameter int WIDTH     = 18
) ();
   import array_writer_pkg::*;

   logic                        start;
   logic signed [WIDTH-1:0]     in_data;
   logic                        in_valid;
   logic                        in_ready;
   logic        [ADDR_BITS-1:0] rd_addr;
   logic signed [WIDTH-1:0]     rd_data;
   logic                        busy;
   logic                        done;
   logic        [ADDR_BITS:0]   wr_count;

   modport master (
      output start, in_data, in_valid, rd_addr,
      input  in_ready, rd_data, busy, done, wr_count
   );

   modport slave (
      input  start, in_data, in_valid, rd_addr,
      output in_ready, rd_data, busy, done, wr_count
   );

endinterface

// File: rtl/array_writer_mem.sv
// DEPTH x WIDTH register file, one write port, one registered read port.
// ARRAY_WRITER_BYPASS_EN selects write-first on a same-address collision.
module array_writer_mem
   import array_writer_pkg::*;
#(
   parameter int ADDR_BITS = 2,
   parameter int WIDTH     = 18
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_wr_en,
   input  logic        [ADDR_BITS-1:0] i_wr_addr,
   input  logic signed [WIDTH-1:0]     i_wr_data,
   input  logic        [ADDR_BITS-1:0] i_rd_addr,
   output logic signed [WIDTH-1:0]     o_rd_data
);

   localparam int DEPTH = depth(ADDR_BITS);

   logic signed [WIDTH-1:0] r_mem [DEPTH];
   logic signed [WIDTH-1:0] r_rd_data;
   logic signed [WIDTH-1:0] w_rd_next;

`ifdef ARRAY_WRITER_BYPASS_EN
   always_comb begin
      w_rd_next = r_mem[i_rd_addr];
      if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
         w_rd_next = i_wr_data;
      end
   end
`else
   // Read-before-write: the array read sees the pre-edge contents.
   always_comb begin
      w_rd_next = r_mem[i_rd_addr];
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_data <= '0;
      end else begin
         if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
         end
         r_rd_data <= w_rd_next;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/array_writer.sv
// Top level: load FSM, write pointer and write counter around the table.
// Optional macro ARRAY_WRITER_BYPASS_EN (see array_writer_mem).
module array_writer
   import array_writer_pkg::*;
#(
   parameter int ADDR_BITS = 2,
   parameter int WIDTH     = 18,
   parameter int EXPONENT  = -12
) (
   input  logic          clk,
   input  logic          rst,
   array_writer_if.slave bus
);

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

   // EXPONENT is format metadata only; reject a binary point outside any sane range.
   if (EXPONENT > WIDTH || EXPONENT < -4 * WIDTH) begin : g_exp_chk
      $error("array_writer: EXPONENT out of range for WIDTH");
   end

   array_writer_state_t         r_state;
   logic        [ADDR_BITS-1:0] r_ptr;
   logic        [ADDR_BITS:0]   r_wr_count;
   logic                        r_busy;
   logic                        r_in_ready;
   logic                        r_done;
   logic                        w_xfer;
   logic signed [WIDTH-1:0]     w_rd_data;

   assign w_xfer = bus.in_valid && r_in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_wr_count <= '0;
         r_busy     <= 1'b0;
         r_in_ready <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  r_state    <= LOAD;
                  r_ptr      <= '0;
                  r_wr_count <= '0;
                  r_done     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_in_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (w_xfer) begin
                  r_ptr      <= r_ptr + ADDR_BITS'(1);
                  r_wr_count <= r_wr_count + (ADDR_BITS+1)'(1);
                  if (r_ptr == LAST_ADDR) begin
                     r_state    <= DONE;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_in_ready <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   array_writer_mem #(
      .ADDR_BITS (ADDR_BITS),
      .WIDTH     (WIDTH)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_xfer),
      .i_wr_addr (r_ptr),
      .i_wr_data (bus.in_data),
      .i_rd_addr (bus.rd_addr),
      .o_rd_data (w_rd_data)
   );

   assign bus.in_ready = r_in_ready;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.wr_count = r_wr_count;
   assign bus.rd_data  = w_rd_data;

endmodule

// File: tb/tb_array_writer.sv
// Directed bench for array_writer (ADDR_BITS=2, WIDTH=18, EXPONENT=-12).
module tb_array_writer;
   import array_writer_pkg::*;

   localparam int AB = 2;
   localparam int W  = 18;

   typedef logic signed [W-1:0] word_t;

   // Q-format constants with 12 fractional bits
   localparam word_t F10   = 18'sd40960;
   localparam word_t FM2P5 = -18'sd10240;
   localparam word_t F0P125 = 18'sd512;
   localparam word_t F7    = 18'sd28672;
   localparam word_t F1    = 18'sd4096;
   localparam word_t F2    = 18'sd8192;
   localparam word_t F3    = 18'sd12288;
   localparam word_t F4    = 18'sd16384;
   localparam word_t F5    = 18'sd20480;
   localparam word_t GARB  = 18'sh1FFFF;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   word_t v[4];
   word_t u[4];
   word_t s[4];

   always #5 clk = ~clk;

   array_writer_if #(.ADDR_BITS(AB), .WIDTH(W)) bus ();

   array_writer #(.ADDR_BITS(AB), .WIDTH(W), .EXPONENT(-12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.rd_addr = '0;
      rst = 1'b0;
      tick(); tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
      checks++; if (bus.wr_count !== 3'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", bus.wr_count); end
      checks++; if (bus.rd_data !== 18'sd0) begin errors++; $display("FAIL reset_rd_data got=%0d exp=0", bus.rd_data); end
      rst = 1'b1;
      tick();
      // valid while idle must not write
      bus.in_valid = 1'b1; bus.in_data = F10;
      tick(); tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got=%0b exp=0", bus.in_ready); end
      checks++; if (bus.wr_count !== 3'd0) begin errors++; $display("FAIL idle_wr_count got=%0d exp=0", bus.wr_count); end
      bus.in_valid = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         tick();
         checks++; if (bus.rd_data !== 18'sd0) begin errors++; $display("FAIL idle_read[%0d] got=%0d exp=0", a, bus.rd_data); end
      end
   endtask

   task automatic test_full_load();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%0b exp=1", bus.busy); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready got=%0b exp=1", bus.in_ready); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL start_done got=%0b exp=0", bus.done); end
      checks++; if (bus.wr_count !== 3'd0) begin errors++; $display("FAIL start_wr_count got=%0d exp=0", bus.wr_count); end
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_data = v[i];
         tick();
         checks++; if (bus.wr_count !== 3'(i + 1)) begin errors++; $display("FAIL full_wr_count[%0d] got=%0d exp=%0d", i, bus.wr_count, i + 1); end
         checks++; if (bus.busy !== (i < 3)) begin errors++; $display("FAIL full_busy[%0d] got=%0b exp=%0b", i, bus.busy, i < 3); end
      end
      bus.in_valid = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL full_done got=%0b exp=1", bus.done); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0b exp=0", bus.in_ready); end
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         tick();
         checks++; if (bus.rd_data !== v[a]) begin errors++; $display("FAIL full_read[%0d] got=%0d exp=%0d", a, bus.rd_data, v[a]); end
      end
   endtask

   task automatic test_toggle();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = (k % 2 == 1);
         bus.in_data  = (k % 2 == 1) ? v[k/2] : GARB;
         tick();
         checks++; if (bus.wr_count !== 3'((k + 1) / 2)) begin errors++; $display("FAIL toggle_wr_count[%0d] got=%0d exp=%0d", k, bus.wr_count, (k + 1) / 2); end
         checks++; if (bus.busy !== (k < 7)) begin errors++; $display("FAIL toggle_busy[%0d] got=%0b exp=%0b", k, bus.busy, k < 7); end
      end
      bus.in_valid = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL toggle_done got=%0b exp=1", bus.done); end
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         tick();
         checks++; if (bus.rd_data !== v[a]) begin errors++; $display("FAIL toggle_read[%0d] got=%0d exp=%0d", a, bus.rd_data, v[a]); end
      end
   endtask

   task automatic test_ignore();
      // valid in DONE has no effect
      bus.in_valid = 1'b1; bus.in_data = GARB;
      tick(); tick(); tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_hold got=%0b exp=1", bus.done); end
      checks++; if (bus.wr_count !== 3'd4) begin errors++; $display("FAIL done_wr_count got=%0d exp=4", bus.wr_count); end
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         tick();
         checks++; if (bus.rd_data !== v[a]) begin errors++; $display("FAIL done_read[%0d] got=%0d exp=%0d", a, bus.rd_data, v[a]); end
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1; bus.in_data = u[i];
         tick();
      end
      // start alone, then start coincident with a transfer
      bus.in_valid = 1'b0; bus.start = 1'b1;
      tick();
      checks++; if (bus.wr_count !== 3'd2) begin errors++; $display("FAIL ign_start_wr_count got=%0d exp=2", bus.wr_count); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_start_busy got=%0b exp=1", bus.busy); end
      bus.in_valid = 1'b1; bus.in_data = u[2];
      tick();
      bus.start = 1'b0;
      checks++; if (bus.wr_count !== 3'd3) begin errors++; $display("FAIL ign_start_xfer_wr_count got=%0d exp=3", bus.wr_count); end
      bus.in_data = u[3];
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done got=%0b exp=1", bus.done); end
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         tick();
         checks++; if (bus.rd_data !== u[a]) begin errors++; $display("FAIL ign_read[%0d] got=%0d exp=%0d", a, bus.rd_data, u[a]); end
      end
   endtask

   task automatic test_reset_midload();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1; bus.in_data = v[i];
         tick();
      end
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%0b exp=0", bus.in_ready); end
      checks++; if (bus.wr_count !== 3'd0) begin errors++; $display("FAIL mid_rst_wr_count got=%0d exp=0", bus.wr_count); end
      checks++; if (bus.rd_data !== 18'sd0) begin errors++; $display("FAIL mid_rst_rd_data got=%0d exp=0", bus.rd_data); end
      #1;
      rst = 1'b1;
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         tick();
         checks++; if (bus.rd_data !== 18'sd0) begin errors++; $display("FAIL mid_rst_read[%0d] got=%0d exp=0", a, bus.rd_data); end
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_data = v[i];
         tick();
      end
      bus.in_valid = 1'b0;
      checks++; if (bus.wr_count !== 3'd4) begin errors++; $display("FAIL reload_wr_count got=%0d exp=4", bus.wr_count); end
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         tick();
         checks++; if (bus.rd_data !== v[a]) begin errors++; $display("FAIL reload_read[%0d] got=%0d exp=%0d", a, bus.rd_data, v[a]); end
      end
   endtask

   task automatic test_same_addr();
      word_t exp_coll;
`ifdef ARRAY_WRITER_BYPASS_EN
      exp_coll = F5;
`else
      exp_coll = F3;
`endif
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_data = s[i];
         tick();
      end
      bus.in_valid = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.rd_addr = 2'd1;
      bus.in_valid = 1'b1; bus.in_data = F7;
      tick();
      bus.in_data = F5;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.rd_data !== exp_coll) begin errors++; $display("FAIL collide_read got=%0d exp=%0d", bus.rd_data, exp_coll); end
      tick();
      checks++; if (bus.rd_data !== F5) begin errors++; $display("FAIL after_collide_read got=%0d exp=%0d", bus.rd_data, F5); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      v[0] = F10; v[1] = FM2P5; v[2] = F0P125; v[3] = F7;
      u[0] = F1;  u[1] = F2;    u[2] = F3;     u[3] = F4;
      s[0] = F1;  s[1] = F3;    s[2] = F2;     s[3] = F4;
      test_reset();
      test_full_load();
      test_toggle();
      test_ignore();
      test_reset_midload();
      test_same_addr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
